// File: rtl/alu_flags_pkg.sv
// Shared definitions for the NZCV flag register and the branch-condition evaluator.
// Latency: none (definitions only).
// Backpressure: none.
package alu_flags_pkg;

    // Bit positions inside a {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;

    // ALU control encodings: bit 1 selects logic ops, bit 0 selects subtract
    localparam int ALU_CTRL_LOGIC_BIT = 1;
    localparam int ALU_CTRL_SUB_BIT   = 0;
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_LOGIC = 3'b010;

    // ARM-style condition codes
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/alu_flags_reg_cond_eval.sv
// Purpose: evaluate a 4-bit ARM condition code against a {N,Z,C,V} flag vector.
// Latency: combinational.
// Backpressure: none.
// Ports: cond (condition code), flags ({N,Z,C,V}), cond_true (condition holds).
module alu_cond_eval
    import alu_flags_pkg::*;
(
    input  logic [3:0] cond,
    input  flags_t     flags,
    output logic       cond_true
);

    logic n, z, c, v;
    logic base;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    // Codes come in pairs: odd code is the complement of the even one.
    // The last pair is AL/NV, so its base is 1 and NV inverts it to 0.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = ~(n ^ v);
            3'd6:    base = ~z & ~(n ^ v);
            default: base = 1'b1;
        endcase
    end

    assign cond_true = base ^ cond[0];

endmodule

// File: rtl/alu_flags_reg.sv
// Purpose: registered NZCV flag store with write mask, sticky flags, saturating overflow counter,
//          registered condition evaluation and (with ALU_FLAG_STACK_EN defined) a flag save/restore LIFO.
// Latency: flags/sticky/counter 1 cycle after upd_i; condition result 1 cycle after cond_valid_i.
// Backpressure: none; one update and one query accepted every cycle.
// Ports: upd_i/upd_mask_i/alu_ctrl_i/a_i/b_i/result_i/c_out_i feed the flag update, clr_i clears,
//        cond_valid_i/cond_i query, push_i/pop_i drive the stack; outputs flags_o, sticky_o, ovf_cnt_o,
//        cond_valid_o/cond_true_o, stk_full_o/stk_empty_o/stk_err_o.
module alu_flags_reg
    import alu_flags_pkg::*;
#(
    parameter int W           = 8,
    parameter int CNT_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             upd_i,
    input  logic [3:0]       upd_mask_i,
    input  logic [2:0]       alu_ctrl_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     result_i,
    input  logic             c_out_i,
    input  logic             clr_i,
    input  logic             cond_valid_i,
    input  logic [3:0]       cond_i,
    input  logic             push_i,
    input  logic             pop_i,
    output flags_t           flags_o,
    output flags_t           sticky_o,
    output logic [CNT_W-1:0] ovf_cnt_o,
    output logic             cond_valid_o,
    output logic             cond_true_o,
    output logic             stk_full_o,
    output logic             stk_empty_o,
    output logic             stk_err_o
);

    flags_t nxt;
    flags_t wr_mask;
    logic   arith;
    logic   cond_hit;
    logic   restore;
    flags_t restore_val;

    assign arith   = ~alu_ctrl_i[ALU_CTRL_LOGIC_BIT];
    assign wr_mask = upd_mask_i;

    // Only sign bits of the operands matter for V; alu_ctrl_i[2] is not used.
    logic unused_ok;
`ifdef ALU_FLAG_STACK_EN
    assign unused_ok = ^{a_i[W-2:0], b_i[W-2:0], alu_ctrl_i[2]};
`else
    assign unused_ok = ^{a_i[W-2:0], b_i[W-2:0], alu_ctrl_i[2], push_i, pop_i};
`endif

    // Candidate flags from the current ALU result. For subtract the effective
    // second operand is ~b, hence the alu_ctrl_i[0] term in the sign compare.
    always_comb begin
        nxt         = '0;
        nxt[FLAG_N] = result_i[W-1];
        nxt[FLAG_Z] = (result_i == '0);
        nxt[FLAG_C] = c_out_i & arith;
        nxt[FLAG_V] = arith & ~(a_i[W-1] ^ b_i[W-1] ^ alu_ctrl_i[ALU_CTRL_SUB_BIT])
                            & (a_i[W-1] ^ result_i[W-1]);
    end

`ifdef ALU_FLAG_STACK_EN
    localparam int PW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(STACK_DEPTH);

    flags_t        stk_mem [STACK_DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;
    logic          push_ok, pop_ok, swap_ok, err_set;

    assign wr_idx  = IW'(ptr);
    assign top_idx = IW'(ptr - 1'b1);

    // clr_i owns the cycle: the stack neither moves nor flags an error.
    always_comb begin
        swap_ok = push_i & pop_i & ~stk_empty_o & ~clr_i;
        push_ok = push_i & ~pop_i & ~stk_full_o & ~clr_i;
        pop_ok  = pop_i & ~push_i & ~stk_empty_o & ~clr_i;
        err_set = ~clr_i & ((push_i & ~pop_i & stk_full_o) |
                            (pop_i & stk_empty_o));
        ptr_nxt = ptr;
        if (push_ok) begin
            ptr_nxt = ptr + 1'b1;
        end else if (pop_ok) begin
            ptr_nxt = ptr - 1'b1;
        end
    end

    assign restore     = pop_ok | swap_ok;
    assign restore_val = stk_mem[top_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            stk_full_o  <= 1'b0;
            stk_empty_o <= 1'b1;
            stk_err_o   <= 1'b0;
        end else begin
            ptr         <= ptr_nxt;
            stk_full_o  <= (ptr_nxt == DEPTH_P);
            stk_empty_o <= (ptr_nxt == '0);
            if (err_set) begin
                stk_err_o <= 1'b1;
            end
        end
    end

    // Stack contents need no reset; a swap overwrites the top in place.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            stk_mem[wr_idx] <= flags_o;
        end else if (swap_ok) begin
            stk_mem[top_idx] <= flags_o;
        end
    end
`else
    assign restore     = 1'b0;
    assign restore_val = '0;
    assign stk_full_o  = 1'b0;
    assign stk_empty_o = 1'b1;
    assign stk_err_o   = 1'b0;
`endif

    // clr beats a restore, and a restore drops the same-cycle update entirely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_o   <= '0;
            sticky_o  <= '0;
            ovf_cnt_o <= '0;
        end else if (clr_i) begin
            flags_o   <= '0;
            sticky_o  <= '0;
            ovf_cnt_o <= '0;
        end else if (restore) begin
            flags_o <= restore_val;
        end else if (upd_i) begin
            flags_o  <= (flags_o & ~wr_mask) | (nxt & wr_mask);
            sticky_o <= sticky_o | (nxt & wr_mask);
            if (wr_mask[FLAG_V] && nxt[FLAG_V] && (ovf_cnt_o != '1)) begin
                ovf_cnt_o <= ovf_cnt_o + 1'b1;
            end
        end
    end

    // Queries see the flags held before this cycle's update.
    alu_cond_eval u_cond_eval (
        .cond      (cond_i),
        .flags     (flags_o),
        .cond_true (cond_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cond_valid_o <= 1'b0;
            cond_true_o  <= 1'b0;
        end else begin
            cond_valid_o <= cond_valid_i;
            cond_true_o  <= cond_valid_i & cond_hit;
        end
    end

endmodule
